mod_red_seq: RTL



---
 rtl/mod_red_seq_pkg.sv | 22 ++
 rtl/mod_red_seq_red_step.sv | 30 +++
 rtl/mod_red_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/mod_red_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_red_seq_pkg
// Brief    : Shared types and constants for the bit-serial modular reducer.
// Revision : 1.0 - initial release
// ============================================================================
package mod_red_seq_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Ed25519 group order L = 2^252 + 27742317777372353535851937790883648493.
  // Callers zero-extend this to their modulus width.
  localparam logic [252:0] ED25519_L =
    253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

endpackage
`default_nettype wire

// File: rtl/mod_red_seq_red_step.sv
`default_nettype none
// ============================================================================
// Module   : red_step
// Brief    : One combinational shift-in / compare / conditional-subtract step
//            of a restoring binary reduction.
// Revision : 1.0 - initial release
// ============================================================================
module red_step #(
  parameter int MOD_WIDTH = 256
) (
  input  logic [MOD_WIDTH:0]   r_i,
  input  logic                 in_bit_i,
  input  logic [MOD_WIDTH-1:0] m_i,
  output logic [MOD_WIDTH:0]   r_next_o,
  output logic                 ge_o
);

  // Full-width shifted value so the compare never loses a carry bit.
  logic [MOD_WIDTH+1:0] t;
  logic [MOD_WIDTH:0]   diff;

  assign t    = {r_i, in_bit_i};
  assign ge_o = (t >= {2'b00, m_i});
  // When ge holds, t < 2m, so the difference fits in MOD_WIDTH+1 bits and
  // the dropped top bit of t cannot matter.
  assign diff     = t[MOD_WIDTH:0] - {1'b0, m_i};
  assign r_next_o = ge_o ? diff : t[MOD_WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/mod_red_seq.sv
`default_nettype none
// ============================================================================
// Module   : mod_red_seq
// Brief    : Sequential r = X mod M, one dividend bit per cycle, wrapped in a
//            start/busy/done controller. Latency IN_WIDTH+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mod_red_seq
  import mod_red_seq_pkg::*;
#(
  parameter int IN_WIDTH  = 512,
  parameter int MOD_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  x_in,
  input  logic [MOD_WIDTH-1:0] mod_in,
  output logic                 busy,
  output logic                 done,
  output logic [MOD_WIDTH-1:0] r_out,
  output logic                 err
);

  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  state_t               state_q;
  logic [IN_WIDTH-1:0]  xs_q;
  logic [MOD_WIDTH-1:0] m_q;
  logic [MOD_WIDTH:0]   r_q;
  logic [MOD_WIDTH:0]   r_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 zflag_q;
  logic                 done_q;
  logic [MOD_WIDTH-1:0] r_out_q;
  logic                 err_q;

  // The MSB of the shift register is the next dividend bit to fold in.
  red_step #(
    .MOD_WIDTH (MOD_WIDTH)
  ) u_step (
    .r_i      (r_q),
    .in_bit_i (xs_q[IN_WIDTH-1]),
    .m_i      (m_q),
    .r_next_o (r_d),
    .ge_o     ()
  );

  // Controller, datapath registers and registered result/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zflag_q <= 1'b0;
      done_q  <= 1'b0;
      r_out_q <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            xs_q  <= x_in;
            m_q   <= mod_in;
            r_q   <= '0;
            cnt_q <= CNT_W'(IN_WIDTH - 1);
            // A zero modulus skips the reduction and is flagged at FIN.
            if (mod_in == '0) begin
              zflag_q <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              zflag_q <= 1'b0;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_q   <= r_d;
          xs_q  <= xs_q << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_out_q <= zflag_q ? '0 : r_q[MOD_WIDTH-1:0];
          err_q   <= zflag_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign r_out = r_out_q;
  assign err   = err_q;

endmodule
`default_nettype wire
